pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_gen.sv | 122 ++++++++++++
 tb/tb_pc_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   pc_state_e       : fetch FSM states (boot, request outstanding, waiting for retire)
//   DefaultResetVec  : default PC after reset
//   DefaultStep      : default sequential increment in bytes
package pc_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } pc_state_e;

    localparam logic [31:0] DefaultResetVec = 32'h8000_0000;
    localparam int unsigned DefaultStep     = 4;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator with a fetch request handshake.
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   commit_i         : current instruction retires
//   jump_i           : retiring instruction is a taken jump (qualified by commit_i)
//   jump_target_i    : jump target
//   trap_i           : trap taken (not qualified by commit_i)
//   trap_vec_i       : trap handler address
//   mret_i           : retiring instruction is MRET (qualified by commit_i)
//   mepc_i           : MRET return address
//   ifu_req_valid_o  : fetch request valid
//   ifu_req_ready_i  : IFU accepts the request
//   pc_o             : current PC / fetch address
//   redirect_o       : one-cycle pulse after a non-sequential PC load
//   misalign_o       : one-cycle pulse on a misaligned jump target
//   misalign_addr_o  : last misaligned target
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DefaultResetVec),
    parameter int unsigned     STEP      = DefaultStep
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            ifu_req_valid_o,
    input  logic            ifu_req_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    // Clears the two low bits of trap/MRET addresses instead of flagging them.
    localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    // Set after a misaligned jump: only a trap can leave WAIT until then.
    logic            trap_pend_q, trap_pend_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = 1'b0;
        misalign_d  = 1'b0;
        maddr_d     = maddr_q;
        trap_pend_d = trap_pend_q;

        unique case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (ifu_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (trap_i) begin
                    pc_d        = trap_vec_i & AlignMask;
                    redirect_d  = 1'b1;
                    trap_pend_d = 1'b0;
                    state_d     = StReq;
                end else if (commit_i && !trap_pend_q) begin
                    if (mret_i) begin
                        pc_d       = mepc_i & AlignMask;
                        redirect_d = 1'b1;
                        state_d    = StReq;
                    end else if (jump_i) begin
                        if (jump_target_i[1:0] != 2'b00) begin
                            misalign_d  = 1'b1;
                            maddr_d     = jump_target_i;
                            trap_pend_d = 1'b1;
                        end else begin
                            pc_d       = jump_target_i;
                            redirect_d = 1'b1;
                            state_d    = StReq;
                        end
                    end else begin
                        pc_d    = pc_q + XLEN'(STEP);
                        state_d = StReq;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_VEC;
            redirect_q  <= 1'b0;
            misalign_q  <= 1'b0;
            maddr_q     <= '0;
            trap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            misalign_q  <= misalign_d;
            maddr_q     <= maddr_d;
            trap_pend_q <= trap_pend_d;
        end
    end

    assign ifu_req_valid_o = (state_q == StReq);
    assign pc_o            = pc_q;
    assign redirect_o      = redirect_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected fetch requests and
// misalign reports; a monitor pops them when the DUT presents them.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_i = 1'b0, jump_i = 1'b0, trap_i = 1'b0, mret_i = 1'b0;
    logic [31:0] jump_target_i = '0, trap_vec_i = '0, mepc_i = '0;
    logic        ifu_req_ready_i = 1'b0;
    logic        ifu_req_valid_o, redirect_o, misalign_o;
    logic [31:0] pc_o, misalign_addr_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        redir;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mis_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .commit_i        (commit_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .trap_vec_i      (trap_vec_i),
        .mret_i          (mret_i),
        .mepc_i          (mepc_i),
        .ifu_req_valid_o (ifu_req_valid_o),
        .ifu_req_ready_i (ifu_req_ready_i),
        .pc_o            (pc_o),
        .redirect_o      (redirect_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: a rising valid is a new fetch request; misalign_o is a report.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifu_req_valid_o && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", pc_o, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_pc", pc_o, e.pc);
                        check("req_redirect", {31'd0, redirect_o}, {31'd0, e.redir});
                    end
                end
                if (misalign_o) begin
                    if (mis_q.size() == 0) begin
                        check("unexpected_misalign", misalign_addr_o, 32'hxxxx_xxxx);
                    end else begin
                        check("misalign_addr", misalign_addr_o, mis_q.pop_front());
                    end
                end
            end
            prev_valid = ifu_req_valid_o;
        end
    end

    // Accept the pending request; returns at a negedge with the DUT in WAIT.
    task automatic to_wait();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_req_valid_o) begin
                ifu_req_ready_i = 1'b1;
                @(negedge clk);
                ifu_req_ready_i = 1'b0;
                return;
            end
        end
        check("request_timeout", 32'd0, 32'd1);
    endtask

    // Drive one cycle of retire/trap inputs starting at the current negedge.
    task automatic fire(input logic tr, input logic cm, input logic jp, input logic mr,
                        input logic [31:0] tgt, input logic [31:0] tv, input logic [31:0] ep);
        trap_i = tr; commit_i = cm; jump_i = jp; mret_i = mr;
        jump_target_i = tgt; trap_vec_i = tv; mepc_i = ep;
        @(negedge clk);
        trap_i = 1'b0; commit_i = 1'b0; jump_i = 1'b0; mret_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, ifu_req_valid_o}, 32'd0);
        check({tag, "_pc"}, pc_o, 32'h8000_0000);
        check({tag, "_redirect"}, {31'd0, redirect_o}, 32'd0);
        check({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
        check({tag, "_maddr"}, misalign_addr_o, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        check_reset_outputs("reset");
        exp_q.push_back('{pc: 32'h8000_0000, redir: 1'b0});
        @(negedge clk); #2 rst_n = 1'b1;
        check("release_valid", {31'd0, ifu_req_valid_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("boot_valid", {31'd0, ifu_req_valid_o}, 32'd1);
        check("boot_pc", pc_o, 32'h8000_0000);

        // Sequential advance.
        to_wait();
        exp_q.push_back('{pc: 32'h8000_0004, redir: 1'b0});
        fire(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);

        // Aligned jump: redirect is a single-cycle pulse.
        to_wait();
        exp_q.push_back('{pc: 32'h8000_0100, redir: 1'b1});
        fire(0, 1, 1, 0, 32'h8000_0100, 32'h0, 32'h0);
        @(negedge clk);
        check("jump_redirect_drop", {31'd0, redirect_o}, 32'd0);
        check("jump_still_req", {31'd0, ifu_req_valid_o}, 32'd1);

        // Wrap from the top of the address space.
        to_wait();
        exp_q.push_back('{pc: 32'hFFFF_FFFC, redir: 1'b1});
        fire(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        to_wait();
        exp_q.push_back('{pc: 32'h0000_0000, redir: 1'b0});
        fire(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);

        // MRET beats jump; low mepc bits are cleared.
        to_wait();
        exp_q.push_back('{pc: 32'h8000_0054, redir: 1'b1});
        fire(0, 1, 1, 1, 32'h1234_5678, 32'h0, 32'h8000_0057);

        // Misaligned jump: PC held, stays in WAIT, further commits ignored.
        to_wait();
        mis_q.push_back(32'h8000_0102);
        fire(0, 1, 1, 0, 32'h8000_0102, 32'h0, 32'h0);
        check("mis_stay_wait", {31'd0, ifu_req_valid_o}, 32'd0);
        check("mis_pc_held", pc_o, 32'h8000_0054);
        @(negedge clk);
        check("mis_pulse_drop", {31'd0, misalign_o}, 32'd0);
        check("mis_addr_held", misalign_addr_o, 32'h8000_0102);
        fire(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
        check("mis_commit_ignored", {31'd0, ifu_req_valid_o}, 32'd0);
        check("mis_commit_pc", pc_o, 32'h8000_0054);
        exp_q.push_back('{pc: 32'h8000_0200, redir: 1'b1});
        fire(1, 0, 0, 0, 32'h0, 32'h8000_0203, 32'h0);

        // Everything at once: trap wins, misaligned target not reported.
        to_wait();
        exp_q.push_back('{pc: 32'h0000_1000, redir: 1'b1});
        fire(1, 1, 1, 1, 32'h8000_0006, 32'h0000_1002, 32'h8000_0400);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_pc", pc_o, 32'h0000_1000);
            check("hold_valid", {31'd0, ifu_req_valid_o}, 32'd1);
        end

        // Asynchronous reset in REQ, checked before the next rising edge.
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.push_back('{pc: 32'h8000_0000, redir: 1'b0});
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("mis_queue_empty", mis_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
